// File: rtl/sdram_port_arbiter.sv
// Two-requester front end for the 8-bit SDRAM port: buffered download writes vs cassette reads.
// Optional SDRAM_ARB_STATS_EN adds saturating completed-write/read counters.
module sdram_port_arbiter #(
  parameter logic [22:0] BASE_ADDR    = 23'h000000,
  parameter int unsigned MAX_WR_BURST = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        cas_req,
  input  logic [22:0] cas_addr,
  output logic [7:0]  cas_data,
  output logic        cas_ack,
  output logic        wr_overflow,
`ifdef SDRAM_ARB_STATS_EN
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
`endif
  output logic [22:0] sdram_addr,
  output logic [7:0]  sdram_din,
  output logic        sdram_rd,
  output logic        sdram_we,
  input  logic [7:0]  sdram_dout,
  input  logic        sdram_ready
);

  typedef struct packed {
    logic [22:0] addr;
    logic [7:0]  data;
  } wr_req_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_WR_BURST);

  state_t     state;
  wr_req_t    hold;
  logic       hold_vld;
  logic       gnt_wr;
  logic [3:0] burst;

  logic issue_wr, wr_accept, pick_wr;
  logic unused_bits;

  // The slot being issued counts as free, so a strobe on that cycle refills it.
  assign issue_wr    = (state == S_ISSUE) && gnt_wr;
  assign wr_accept   = ioctl_wr && (!hold_vld || issue_wr);
  assign pick_wr     = hold_vld && (!cas_req || (burst < BURST_MAX));
  assign unused_bits = &{1'b0, ioctl_addr[24:23], ioctl_download};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= S_IDLE;
      hold        <= '0;
      hold_vld    <= 1'b0;
      gnt_wr      <= 1'b0;
      burst       <= '0;
      sdram_addr  <= '0;
      sdram_din   <= '0;
      sdram_rd    <= 1'b0;
      sdram_we    <= 1'b0;
      cas_data    <= '0;
      cas_ack     <= 1'b0;
      wr_overflow <= 1'b0;
    end else begin
      cas_ack <= 1'b0;

      if (wr_accept) begin
        hold     <= '{addr: ioctl_addr[22:0], data: ioctl_dout};
        hold_vld <= 1'b1;
      end else if (issue_wr) begin
        hold_vld <= 1'b0;
      end
      if (ioctl_wr && !wr_accept)
        wr_overflow <= 1'b1;

      case (state)
        S_IDLE: begin
          if (sdram_ready && (hold_vld || cas_req)) begin
            state <= S_ISSUE;
            if (pick_wr) begin
              gnt_wr     <= 1'b1;
              sdram_we   <= 1'b1;
              sdram_addr <= hold.addr + BASE_ADDR;
              sdram_din  <= hold.data;
              burst      <= cas_req ? burst + 4'd1 : 4'd0;
            end else begin
              gnt_wr     <= 1'b0;
              sdram_rd   <= 1'b1;
              sdram_addr <= cas_addr + BASE_ADDR;
              burst      <= '0;
            end
          end
        end
        S_ISSUE: begin
          sdram_rd <= 1'b0;
          sdram_we <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // Read data is only valid on the cycle ready returns.
          if (sdram_ready) begin
            state <= S_DONE;
            if (!gnt_wr) begin
              cas_data <= sdram_dout;
              cas_ack  <= 1'b1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  logic dl_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q     <= 1'b0;
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      dl_q <= ioctl_download;
      if (ioctl_download && !dl_q)
        wr_count <= '0;
      else if ((state == S_DONE) && gnt_wr && (wr_count != 16'hFFFF))
        wr_count <= wr_count + 16'd1;
      if ((state == S_DONE) && !gnt_wr && (rd_count != 16'hFFFF))
        rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench for sdram_port_arbiter: SDRAM model, write scoreboard and read data/latency model.
`timescale 1ns/1ps
module tb_sdram_port_arbiter;
  localparam logic [22:0] BASE = 23'h010000;
  localparam int MAXB = 4;

  logic clk_sys = 1'b0;
  always #10 clk_sys = ~clk_sys;

  logic        reset = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0, cas_req = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0, sdram_dout = '0;
  logic [22:0] cas_addr = '0;
  logic        sdram_ready = 1'b1;
  logic [7:0]  cas_data, sdram_din;
  logic        cas_ack, wr_overflow, sdram_rd, sdram_we;
  logic [22:0] sdram_addr;
`ifdef SDRAM_ARB_STATS_EN
  logic [15:0] wr_count, rd_count;
`endif

  sdram_port_arbiter #(.BASE_ADDR(BASE), .MAX_WR_BURST(MAXB)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .cas_req(cas_req), .cas_addr(cas_addr), .cas_data(cas_data), .cas_ack(cas_ack),
    .wr_overflow(wr_overflow),
`ifdef SDRAM_ARB_STATS_EN
    .wr_count(wr_count), .rd_count(rd_count),
`endif
    .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_rd(sdram_rd),
    .sdram_we(sdram_we), .sdram_dout(sdram_dout), .sdram_ready(sdram_ready));

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference state
  typedef struct { logic [22:0] a; logic [7:0] d; } wr_t;
  wr_t         wq[$];
  logic [7:0]  mem [logic [22:0]];
  logic        ovf_exp = 1'b0, cas_req_q = 1'b0, force_busy = 1'b0, rec = 1'b0;
  logic [7:0]  rd_val = '0, exp_cas = '0, last_din = '0;
  logic [22:0] last_waddr = '0;
  logic [31:0] gbits = '0;
  int busy_left = 0, busy_min = 1, busy_max = 4, cyc = 0, rd_cyc = 0, rd_busy = 0;
  int rd_cmds = 0, rd_total = 0, wr_total = 0, acks = 0, wr_run = 0, gcnt = 0;

  function automatic logic [7:0] mem_rd(input logic [22:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  // SDRAM controller model: ready low for the chosen busy time after each command
  always @(posedge clk_sys) begin
    #1;
    cyc++;
    if (force_busy || busy_left > 0) begin
      sdram_ready = 1'b0;
      sdram_dout  = 8'($urandom);
      if (busy_left > 0) busy_left--;
    end else begin
      sdram_ready = 1'b1;
      sdram_dout  = rd_val;
    end
  end

  always @(negedge clk_sys) begin
    logic        acc;
    logic [22:0] ea;
    wr_t         w;
    if (reset) begin
      wq.delete(); ovf_exp = 1'b0; busy_left = 0; rd_cmds = 0; wr_run = 0; cas_req_q = 1'b0;
    end else begin
      chk("wr_overflow", wr_overflow, ovf_exp);
      acc = (wq.size() == 0) || sdram_we;
      if (sdram_we || sdram_rd) begin
        chk("cmd_when_ready", sdram_ready, 1);
        chk("cmd_exclusive", sdram_we && sdram_rd, 0);
        busy_left = $urandom_range(busy_max, busy_min);
        if (rec && gcnt < 10) begin gbits = {gbits[30:0], sdram_we}; gcnt++; end
      end
      if (sdram_we) begin
        wr_total++;
        last_waddr = sdram_addr; last_din = sdram_din;
        chk("wr_has_pending", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          w = wq.pop_front();
          chk("wr_addr", sdram_addr, w.a);
          chk("wr_data", sdram_din, w.d);
          mem[w.a] = w.d;
        end
        wr_run = cas_req_q ? wr_run + 1 : 0;
        chk("wr_burst_limit", wr_run <= MAXB, 1);
      end
      if (sdram_rd) begin
        ea = cas_addr + BASE;
        chk("rd_addr", sdram_addr, ea);
        rd_val = mem_rd(ea); exp_cas = rd_val;
        rd_cyc = cyc; rd_busy = busy_left; rd_cmds++; rd_total++; wr_run = 0;
      end
      if (cas_ack) begin
        acks++;
        chk("ack_data", cas_data, exp_cas);
        chk("ack_latency", cyc - rd_cyc, 2 + rd_busy);
        chk("rd_cmds_per_ack", rd_cmds, 1);
        rd_cmds = 0;
      end
      if (ioctl_wr) begin
        if (acc) wq.push_back('{a: ioctl_addr[22:0] + BASE, d: ioctl_dout});
        else ovf_exp = 1'b1;
      end
      cas_req_q = cas_req;
    end
  end

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d; tick(); ioctl_wr = 1'b0;
  endtask

  task automatic rd_req(input logic [22:0] a, output logic [7:0] d);
    int n = 0;
    cas_req = 1'b1; cas_addr = a;
    while (n <= 300) begin @(negedge clk_sys); if (cas_ack) break; n++; end
    chk("rd_timeout", n <= 300, 1);
    d = cas_data;
    tick(); cas_req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((wq.size() != 0 || !sdram_ready || busy_left != 0) && n < 300) begin tick(); n++; end
    repeat (6) tick();
    chk("drain_timeout", n < 300, 1);
    chk("drain_empty", wq.size(), 0);
  endtask

  initial begin
    logic [7:0] d;
    int n, w0, a0;
    logic stop;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_addr", sdram_addr, 0); chk("rst_din", sdram_din, 0);
    chk("rst_rd", sdram_rd, 0); chk("rst_we", sdram_we, 0);
    chk("rst_cas_data", cas_data, 0); chk("rst_ack", cas_ack, 0); chk("rst_ovf", wr_overflow, 0);

    // single write, upper address bits must be ignored
    w0 = wr_total;
    wr({2'b11, 23'h000123}, 8'hA5);
    drain();
    chk("t1_wr_count", wr_total - w0, 1);
    chk("t1_addr", last_waddr, 23'h010123);
    chk("t1_din", last_din, 8'hA5);
    chk("t1_ovf", wr_overflow, 0);

    // single read, 5 busy cycles
    mem[23'h010040] = 8'h3C;
    busy_min = 5; busy_max = 5;
    w0 = rd_total;
    rd_req(23'h000040, d);
    chk("t2_data", d, 8'h3C);
    chk("t2_rd_count", rd_total - w0, 1);
    busy_min = 1; busy_max = 4;
    // address wrap past 2^23
    mem[23'h00FFF0] = 8'hC3;
    rd_req(23'h7FFFF0, d);
    chk("wrap_data", d, 8'hC3);
    repeat (3) tick();

    // contention: write pending every cycle, read held
    stop = 1'b0; gcnt = 0; gbits = '0; rec = 1'b1;
    fork
      begin
        while (!stop) begin
          ioctl_wr = 1'b1; ioctl_addr = 25'($urandom); ioctl_dout = 8'($urandom); tick();
        end
        ioctl_wr = 1'b0;
      end
      begin
        tick();
        cas_req = 1'b1; cas_addr = 23'($urandom);
        for (int k = 0; k < 2; k++) begin
          n = 0;
          while (n <= 300) begin @(negedge clk_sys); if (cas_ack) break; n++; end
          chk("cont_timeout", n <= 300, 1);
          tick();
          if (k == 0) cas_addr = 23'($urandom);
          else begin cas_req = 1'b0; stop = 1'b1; end
        end
      end
    join
    rec = 1'b0;
    drain();
    chk("cont_order", gbits, 32'h3DE);
    chk("cont_grants", gcnt, 10);
    chk("cont_ovf", wr_overflow, 1);
    do_reset();
    chk("ovf_cleared", wr_overflow, 0);

    // overflow while the controller is busy
    force_busy = 1'b1; tick(); tick();
    w0 = wr_total;
    wr(25'h000200, 8'h11); tick();
    wr(25'h000201, 8'h22); tick();
    chk("ovf_set", wr_overflow, 1);
    force_busy = 1'b0;
    drain();
    chk("ovf_one_write", wr_total - w0, 1);
    chk("ovf_second_dropped", mem.exists(23'h010201), 0);
    chk("ovf_sticky", wr_overflow, 1);
    do_reset();
    chk("ovf_reset", wr_overflow, 0);

    // reset while waiting on a read
    busy_min = 10; busy_max = 10;
    w0 = rd_total; a0 = acks; n = 0;
    cas_req = 1'b1; cas_addr = 23'h000777;
    while (rd_total == w0 && n < 50) begin @(negedge clk_sys); n++; end
    chk("rstw_issue", rd_total - w0, 1);
    tick(); tick();
    reset = 1'b1; cas_req = 1'b0; tick(); reset = 1'b0;
    chk("rstw_addr", sdram_addr, 0); chk("rstw_rd", sdram_rd, 0);
    chk("rstw_ack", cas_ack, 0); chk("rstw_data", cas_data, 0);
    repeat (12) tick();
    chk("rstw_no_ack", acks - a0, 0);
    busy_min = 1; busy_max = 4;
    rd_req(23'h000777, d);
    chk("rstw_next_rd", d, mem_rd(23'h010777));

    // randomized traffic
    busy_min = 1; busy_max = 6; stop = 1'b0;
    fork
      begin
        for (int i = 0; i < 1500; i++) begin
          ioctl_wr = ($urandom_range(3) == 0);
          ioctl_addr = 25'($urandom); ioctl_dout = 8'($urandom);
          tick();
        end
        ioctl_wr = 1'b0; stop = 1'b1;
      end
      begin
        while (!stop) begin
          repeat ($urandom_range(5)) tick();
          rd_req(23'($urandom), d);
        end
      end
    join
    drain();
    busy_min = 1; busy_max = 4;

`ifdef SDRAM_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin wr(25'(i), 8'(i + 1)); drain(); end
    rd_req(23'h000010, d); rd_req(23'h000020, d);
    repeat (3) tick();
    chk("stat_wr", wr_count, 3);
    chk("stat_rd", rd_count, 2);
    ioctl_download = 1'b1; tick(); tick();
    chk("stat_wr_clr", wr_count, 0);
    chk("stat_rd_keep", rd_count, 2);
    ioctl_download = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end
endmodule
